// File: rtl/mem_stage_unit.sv
// -----------------------------------------------------------------------------
// mem_stage_unit
//
// Purpose:
//    EX/MEM pipeline register, byte-enable generator for the memory access,
//    and a 2-read / 1-write register file with write-through bypass.
//
// Ports:
//    clk                 sole clock, rising edge
//    reset               asynchronous, active-low reset
//    ex_ir/pc4/ao/rt/sd  EX-stage values, captured every edge (no stall)
//    mem_ir/pc4/ao/rt/sd registered copies of the ex_* inputs
//    be_type             access size: 0 word, 1 halfword, 2 byte, 3-7 none
//    be                  byte enables from mem_ao[1:0] and be_type
//    rd_addr1/2          register-file read addresses
//    rd_data1/2          register-file read data (combinational)
//    wr_addr/wr_en/wr_data register-file write port
// -----------------------------------------------------------------------------
module mem_stage_unit #(
   parameter int DW   = 32,
   parameter int NREG = 32
) (
   input  logic          clk,
   input  logic          reset,
   input  logic [DW-1:0] ex_ir,
   input  logic [DW-1:0] ex_pc4,
   input  logic [DW-1:0] ex_ao,
   input  logic [DW-1:0] ex_rt,
   input  logic [DW-1:0] ex_sd,
   output logic [DW-1:0] mem_ir,
   output logic [DW-1:0] mem_pc4,
   output logic [DW-1:0] mem_ao,
   output logic [DW-1:0] mem_rt,
   output logic [DW-1:0] mem_sd,
   input  logic [2:0]    be_type,
   output logic [3:0]    be,
   input  logic [4:0]    rd_addr1,
   input  logic [4:0]    rd_addr2,
   output logic [DW-1:0] rd_data1,
   output logic [DW-1:0] rd_data2,
   input  logic [4:0]    wr_addr,
   input  logic          wr_en,
   input  logic [DW-1:0] wr_data
);

   logic [DW-1:0] mem_ir_q,  mem_ir_d;
   logic [DW-1:0] mem_pc4_q, mem_pc4_d;
   logic [DW-1:0] mem_ao_q,  mem_ao_d;
   logic [DW-1:0] mem_rt_q,  mem_rt_d;
   logic [DW-1:0] mem_sd_q,  mem_sd_d;

   // Register 0 has no storage: it is hard-wired to zero on the read side.
   logic [DW-1:0] regs_q [1:NREG-1];
   logic [DW-1:0] regs_d [1:NREG-1];

   logic bypass1;
   logic bypass2;

   // Next-state: the pipeline register loads unconditionally; bubbles are
   // simply ex_ir=0 from upstream and need no special treatment here.
   always_comb begin
      mem_ir_d  = ex_ir;
      mem_pc4_d = ex_pc4;
      mem_ao_d  = ex_ao;
      mem_rt_d  = ex_rt;
      mem_sd_d  = ex_sd;
      for (int i = 1; i < NREG; i++) begin
         regs_d[i] = regs_q[i];
         if (wr_en && (wr_addr == 5'(i))) begin
            regs_d[i] = wr_data;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         mem_ir_q  <= '0;
         mem_pc4_q <= '0;
         mem_ao_q  <= '0;
         mem_rt_q  <= '0;
         mem_sd_q  <= '0;
         for (int i = 1; i < NREG; i++) begin
            regs_q[i] <= '0;
         end
      end else begin
         mem_ir_q  <= mem_ir_d;
         mem_pc4_q <= mem_pc4_d;
         mem_ao_q  <= mem_ao_d;
         mem_rt_q  <= mem_rt_d;
         mem_sd_q  <= mem_sd_d;
         for (int i = 1; i < NREG; i++) begin
            regs_q[i] <= regs_d[i];
         end
      end
   end

   assign mem_ir  = mem_ir_q;
   assign mem_pc4 = mem_pc4_q;
   assign mem_ao  = mem_ao_q;
   assign mem_rt  = mem_rt_q;
   assign mem_sd  = mem_sd_q;

   // Byte enables. Misaligned word/halfword accesses produce no enables.
   always_comb begin
      be = 4'b0000;
      case (be_type)
         3'd0: begin
            if (mem_ao_q[1:0] == 2'b00) begin
               be = 4'b1111;
            end
         end
         3'd1: begin
            case (mem_ao_q[1:0])
               2'b00:   be = 4'b0011;
               2'b10:   be = 4'b1100;
               default: be = 4'b0000;
            endcase
         end
         3'd2: begin
            be = 4'b0001 << mem_ao_q[1:0];
         end
         default: begin
            be = 4'b0000;
         end
      endcase
   end

   // Write-through bypass: a write in flight is visible on the read ports in
   // the same cycle, so the consumer never sees the stale register value.
   assign bypass1 = wr_en && (wr_addr != 5'd0) && (wr_addr == rd_addr1);
   assign bypass2 = wr_en && (wr_addr != 5'd0) && (wr_addr == rd_addr2);

   always_comb begin
      rd_data1 = '0;
      rd_data2 = '0;
      for (int i = 1; i < NREG; i++) begin
         if (rd_addr1 == 5'(i)) begin
            rd_data1 = regs_q[i];
         end
         if (rd_addr2 == 5'(i)) begin
            rd_data2 = regs_q[i];
         end
      end
      if (bypass1) begin
         rd_data1 = wr_data;
      end
      if (bypass2) begin
         rd_data2 = wr_data;
      end
   end

endmodule

// File: tb/tb_mem_stage_unit.sv
module tb_mem_stage_unit;

   localparam int DW = 32;

   // ---------------- clock / reset ----------------
   logic          clk;
   logic          reset;
   logic [DW-1:0] ex_ir, ex_pc4, ex_ao, ex_rt, ex_sd;
   logic [DW-1:0] mem_ir, mem_pc4, mem_ao, mem_rt, mem_sd;
   logic [2:0]    be_type;
   logic [3:0]    be;
   logic [4:0]    rd_addr1, rd_addr2, wr_addr;
   logic [DW-1:0] rd_data1, rd_data2, wr_data;
   logic          wr_en;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   mem_stage_unit #(.DW(DW), .NREG(32)) dut (
      .clk      (clk),
      .reset    (reset),
      .ex_ir    (ex_ir),
      .ex_pc4   (ex_pc4),
      .ex_ao    (ex_ao),
      .ex_rt    (ex_rt),
      .ex_sd    (ex_sd),
      .mem_ir   (mem_ir),
      .mem_pc4  (mem_pc4),
      .mem_ao   (mem_ao),
      .mem_rt   (mem_rt),
      .mem_sd   (mem_sd),
      .be_type  (be_type),
      .be       (be),
      .rd_addr1 (rd_addr1),
      .rd_addr2 (rd_addr2),
      .rd_data1 (rd_data1),
      .rd_data2 (rd_data2),
      .wr_addr  (wr_addr),
      .wr_en    (wr_en),
      .wr_data  (wr_data)
   );

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- scoreboard / model ----------------
   int n_cmp = 0;
   int n_err = 0;
   logic [5*DW-1:0] exp_q[$];
   logic [DW-1:0]   model_rf [32];
   logic [DW-1:0]   model_ao;

   task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Byte-enable rule written from the access-size table.
   function automatic logic [3:0] model_be(input logic [1:0] ao, input logic [2:0] bt);
      int a;
      a = int'(ao);
      case (bt)
         3'd0:    return (a == 0) ? 4'd15 : 4'd0;
         3'd1:    return (a == 0) ? 4'd3 : ((a == 2) ? 4'd12 : 4'd0);
         3'd2:    return 4'(1 << a);
         default: return 4'd0;
      endcase
   endfunction

   function automatic logic [DW-1:0] model_read(input logic [4:0] ra);
      if (ra == 5'd0) return '0;
      if (wr_en && wr_addr != 5'd0 && wr_addr == ra) return wr_data;
      return model_rf[ra];
   endfunction

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_ex(input logic [DW-1:0] ir, pc4, ao, rt, sd);
      ex_ir = ir; ex_pc4 = pc4; ex_ao = ao; ex_rt = rt; ex_sd = sd;
   endtask

   task automatic drive_wr(input logic en, input logic [4:0] a, input logic [DW-1:0] d);
      wr_en = en; wr_addr = a; wr_data = d;
   endtask

   task automatic check_mem(input string tag, input logic [5*DW-1:0] e);
      check({tag, ".mem_ir"},  mem_ir,  e[5*DW-1:4*DW]);
      check({tag, ".mem_pc4"}, mem_pc4, e[4*DW-1:3*DW]);
      check({tag, ".mem_ao"},  mem_ao,  e[3*DW-1:2*DW]);
      check({tag, ".mem_rt"},  mem_rt,  e[2*DW-1:DW]);
      check({tag, ".mem_sd"},  mem_sd,  e[DW-1:0]);
   endtask

   // ---------------- byte-enable vector table ----------------
   typedef struct {
      logic [1:0] ao;
      logic [2:0] bt;
      logic [3:0] exp_be;
   } be_vec_t;

   be_vec_t be_tab[16];

   logic [5*DW-1:0] e;
   logic [DW-1:0]   v;

   initial begin
      be_tab[0]  = '{2'b00, 3'd2, 4'b0001};
      be_tab[1]  = '{2'b01, 3'd2, 4'b0010};
      be_tab[2]  = '{2'b10, 3'd2, 4'b0100};
      be_tab[3]  = '{2'b11, 3'd2, 4'b1000};
      be_tab[4]  = '{2'b10, 3'd1, 4'b1100};
      be_tab[5]  = '{2'b01, 3'd1, 4'b0000};
      be_tab[6]  = '{2'b00, 3'd1, 4'b0011};
      be_tab[7]  = '{2'b11, 3'd1, 4'b0000};
      be_tab[8]  = '{2'b00, 3'd0, 4'b1111};
      be_tab[9]  = '{2'b01, 3'd0, 4'b0000};
      be_tab[10] = '{2'b10, 3'd0, 4'b0000};
      be_tab[11] = '{2'b11, 3'd0, 4'b0000};
      be_tab[12] = '{2'b00, 3'd3, 4'b0000};
      be_tab[13] = '{2'b00, 3'd7, 4'b0000};
      be_tab[14] = '{2'b10, 3'd5, 4'b0000};
      be_tab[15] = '{2'b11, 3'd4, 4'b0000};

      // Reset state: assert reset with a clean negedge at time 1.
      reset = 1'b1;
      drive_ex('0, '0, '0, '0, '0);
      drive_wr(1'b0, 5'd0, '0);
      be_type = 3'd0; rd_addr1 = 5'd1; rd_addr2 = 5'd31;
      #1 reset = 1'b0;
      #1;
      check_mem("reset", '0);
      check("reset.be", {28'd0, be}, 32'h0000_000F);
      check("reset.rd1", rd_data1, '0);
      check("reset.rd2", rd_data2, '0);
      tick();
      reset = 1'b1;

      // Pipeline load and bubble.
      drive_ex(32'h8C22_0004, 32'h0000_1004, 32'h1234_5678, 32'h0000_0042, 32'h0000_0099);
      tick();
      check_mem("pipe1", {32'h8C22_0004, 32'h0000_1004, 32'h1234_5678, 32'h0000_0042, 32'h0000_0099});
      drive_ex('0, 32'h0000_1008, 32'h0000_0010, '0, '0);
      tick();
      check("bubble.mem_ir", mem_ir, '0);
      check("bubble.mem_pc4", mem_pc4, 32'h0000_1008);

      // Byte-enable table.
      for (int i = 0; i < 16; i++) begin
         v = ($urandom() & 32'hFFFF_FFFC) | {30'd0, be_tab[i].ao};
         ex_ao = v;
         tick();
         be_type = be_tab[i].bt;
         #1;
         check($sformatf("be_tab%0d", i), {28'd0, be}, {28'd0, be_tab[i].exp_be});
      end

      // Register file writes, r0 protection.
      drive_wr(1'b1, 5'd5, 32'hDEAD_BEEF);
      tick();
      drive_wr(1'b1, 5'd0, 32'hFFFF_FFFF);
      rd_addr1 = 5'd5; rd_addr2 = 5'd0;
      #1;
      check("rf.r5", rd_data1, 32'hDEAD_BEEF);
      check("rf.r0_during_write", rd_data2, '0);
      tick();
      drive_wr(1'b0, 5'd0, '0);
      #1;
      check("rf.r0_after_write", rd_data2, '0);

      // Bypass on both ports, then the value persists.
      drive_wr(1'b1, 5'd7, 32'hA5A5_A5A5);
      rd_addr1 = 5'd7; rd_addr2 = 5'd7;
      #1;
      check("bypass.rd1", rd_data1, 32'hA5A5_A5A5);
      check("bypass.rd2", rd_data2, 32'hA5A5_A5A5);
      tick();
      drive_wr(1'b1, 5'd8, 32'h0BAD_F00D);
      #1;
      check("bypass.r7_stored", rd_data1, 32'hA5A5_A5A5);
      tick();
      drive_wr(1'b0, 5'd0, '0);

      // Async reset between edges, pending write ignored, then recovery.
      drive_ex(32'h1111_1111, 32'h2222_2222, 32'h3333_3331, 32'h4444_4444, 32'h5555_5555);
      drive_wr(1'b1, 5'd9, 32'h1111_2222);
      tick();
      drive_wr(1'b1, 5'd10, 32'h7777_7777);
      #2 reset = 1'b0;
      #1;
      check_mem("areset", '0);
      be_type = 3'd0;
      drive_wr(1'b0, 5'd0, '0);
      for (int i = 1; i < 32; i++) begin
         rd_addr1 = 5'(i); rd_addr2 = 5'(i);
         #1;
         check($sformatf("areset.rd1_r%0d", i), rd_data1, '0);
         check($sformatf("areset.rd2_r%0d", i), rd_data2, '0);
      end
      check("areset.be", {28'd0, be}, 32'h0000_000F);
      drive_wr(1'b1, 5'd10, 32'h7777_7777);
      tick();
      check("areset.edge_ignored", mem_ir, '0);
      reset = 1'b1;
      drive_wr(1'b0, 5'd0, '0);
      rd_addr1 = 5'd10;
      #1;
      check("areset.r10_dropped", rd_data1, '0);
      drive_wr(1'b1, 5'd4, 32'hCAFE_0004);
      tick();
      check_mem("areset.first_load",
                {32'h1111_1111, 32'h2222_2222, 32'h3333_3331, 32'h4444_4444, 32'h5555_5555});
      drive_wr(1'b0, 5'd0, '0);
      rd_addr1 = 5'd4;
      #1;
      check("areset.first_write", rd_data1, 32'hCAFE_0004);

      // Randomized run against the reference model.
      for (int i = 0; i < 32; i++) model_rf[i] = '0;
      model_rf[4] = 32'hCAFE_0004;
      model_ao = 32'h3333_3331;
      for (int k = 0; k < 400; k++) begin
         drive_ex($urandom(), $urandom(), $urandom(), $urandom(), $urandom());
         if ($urandom_range(0, 7) == 0) ex_ir = '0;
         be_type = 3'($urandom_range(0, 7));
         drive_wr(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom());
         rd_addr1 = ($urandom_range(0, 3) == 0) ? wr_addr : 5'($urandom_range(0, 31));
         rd_addr2 = ($urandom_range(0, 3) == 0) ? wr_addr : 5'($urandom_range(0, 31));
         #1;
         check("rand.rd1", rd_data1, model_read(rd_addr1));
         check("rand.rd2", rd_data2, model_read(rd_addr2));
         check("rand.be", {28'd0, be}, {28'd0, model_be(model_ao[1:0], be_type)});
         exp_q.push_back({ex_ir, ex_pc4, ex_ao, ex_rt, ex_sd});
         if (wr_en && wr_addr != 5'd0) model_rf[wr_addr] = wr_data;
         model_ao = ex_ao;
         tick();
         e = exp_q.pop_front();
         check_mem("rand", e);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/mem_stage_unit.md
MEM_STAGE_UNIT -- requirements
Module: mem_stage_unit

Interface
Parameters (name, default, meaning):
REQ-001 DW, 32, datapath width; all data, IR and PC buses are DW bits wide.
REQ-002 NREG, 32, register-file depth; register addresses are 5 bits.

Ports (name, direction, width, meaning). One clock; reset is asynchronous and active-low.
REQ-003 clk  in  1  sole clock; all state updates on its rising edge.
REQ-004 reset  in  1  asynchronous, active-low reset.
REQ-005 ex_ir, ex_pc4, ex_ao, ex_rt, ex_sd  in  32 each  EX-stage instruction, PC+4, ALU result, raw rt value, forwarded store data.
REQ-006 mem_ir, mem_pc4, mem_ao, mem_rt, mem_sd  out  32 each  registered EX/MEM copies of the five inputs above.
REQ-007 be_type  in  3  access size: 0 = word, 1 = halfword, 2 = byte, 3-7 = none.
REQ-008 be  out  4  byte enables, combinational from mem_ao[1:0] and be_type.
REQ-009 rd_addr1, rd_addr2  in  5  register-file read addresses.
REQ-010 rd_data1, rd_data2  out  32  register-file read data, combinational.
REQ-011 wr_addr  in  5  register-file write address.
REQ-012 wr_en  in  1  register-file write enable.
REQ-013 wr_data  in  32  register-file write data.

Function
REQ-014 EX/MEM register: every rising clk edge with reset high, the unit SHALL load all five ex_* inputs into the matching mem_* outputs; there is no enable or stall, so latency is exactly 1 cycle.
REQ-015 Bubbles are produced upstream by driving ex_ir=0; the unit SHALL pass the zero IR through unchanged with no special handling.
REQ-016 Byte enables for be_type=0: be=4'b1111 when mem_ao[1:0]=00, otherwise 4'b0000 (misaligned word access).
REQ-017 Byte enables for be_type=1: be=4'b0011 when mem_ao[1:0]=00, 4'b1100 when mem_ao[1:0]=10, otherwise 4'b0000.
REQ-018 Byte enables for be_type=2: be=4'b0001 shifted left by mem_ao[1:0] (0001, 0010, 0100, 1000).
REQ-019 Byte enables for be_type 3-7: be=4'b0000.
REQ-020 Register file: NREG x 32 bits; on a rising clk edge with wr_en=1 and wr_addr!=0, reg[wr_addr] SHALL take wr_data.
REQ-021 Register 0 SHALL always read 0; writes to it SHALL be ignored.
REQ-022 Reads are asynchronous: rd_dataN=reg[rd_addrN].
REQ-023 Write-through bypass: when wr_en=1, wr_addr!=0 and wr_addr==rd_addrN, rd_dataN SHALL equal wr_data in the same cycle.
REQ-024 The bypass SHALL apply to both read ports independently, including when both ports read the register being written.

Reset
REQ-025 When reset goes low, all mem_* outputs and all 32 registers SHALL clear to 0 immediately, without waiting for a clock edge.
REQ-026 While reset is low, clock edges SHALL be ignored, including any pending register-file write.
REQ-027 be SHALL follow REQ-016..019 from the cleared mem_ao (0) during reset; with be_type=0 this gives be=1111.
REQ-028 After reset deasserts, the first rising clk edge SHALL perform a normal load and write.
REQ-029 Asserting reset mid-operation SHALL discard any value written earlier, including in the same cycle.

Verification
REQ-030 Pipeline: ex_ao=0x12345678, ex_ir=0x8C220004, then an edge -> mem_ao=0x12345678 and mem_ir=0x8C220004; the next edge with ex_ir=0 -> mem_ir=0.
REQ-031 Byte enables: with mem_ao low bits 00/01/10/11, be_type=2 -> be=0001/0010/0100/1000; be_type=1 with 10 -> 1100, with 01 -> 0000; be_type=0 with 00 -> 1111.
REQ-032 Register file: write 0xDEADBEEF to r5 -> rd_addr1=5 returns 0xDEADBEEF; write 0xFFFFFFFF to r0 -> rd_addr2=0 returns 0.
REQ-033 Bypass: wr_en=1, wr_addr=7, wr_data=0xA5A5A5A5, rd_addr1=rd_addr2=7 before the edge -> both read ports return 0xA5A5A5A5 combinationally.
REQ-034 Async reset: load nonzero values, then pull reset low between edges -> all mem_* outputs and r1..r31 read 0 immediately; the first edge after release loads normally.
